goertzel_frame_ctrl: RTL and testbench
======================================

// Module: goertzel_frame_ctrl
// PURPOSE
//  Frame sequencer for the goertzel_filter datapath. Accepts a sample stream (valid/ready),
//  clears the filter state, feeds exactly frame_len samples, waits out the magnitude pipeline,
//  then captures the magnitude. Compares the magnitude against a threshold and presents the
//  result on a valid/ready output. Single-shot or continuous frame mode.
// PARAMETERS
//  SAMPLE_W  14   sample width; matches filter input_signal
//  MAG_W     40   magnitude width; matches filter magnitude
//  CNT_W     8    width of frame_len and the sample counter
//  N_MAX     205  largest legal frame length
//  FLT_LAT   2    cycles from last flt_en to a valid flt_mag
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active low
//  start      in   1         begin frame(s); honoured in IDLE only
//  cont       in   1         continuous mode; sampled with start
//  abort      in   1         synchronous abort, any state
//  frame_len  in   CNT_W     samples per frame; sampled with start
//  threshold  in   MAG_W     detect threshold, unsigned; sampled at capture
//  s_valid    in   1         sample valid
//  s_ready    out  1         sample ready
//  s_data     in   SAMPLE_W  sample
//  flt_clr    out  1         synchronous clear of filter q1/q2
//  flt_en     out  1         filter sample strobe
//  flt_data   out  SAMPLE_W  filter sample
//  flt_mag    in   MAG_W     filter magnitude
//  m_valid    out  1         result valid
//  m_ready    in   1         result accepted
//  m_mag      out  MAG_W     captured magnitude
//  m_detect   out  1         m_mag >= threshold
//  m_frame    out  16        frame index of the result; wraps at 0xFFFF->0
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE. All outputs are 0. cnt, m_frame counter and the
//   latched config are 0.
//  States: IDLE, CLEAR, RUN, DRAIN, HOLD.
//  IDLE: s_ready=0. On start, latch frame_len and cont, then go to CLEAR.
//   frame_len=0 or frame_len>N_MAX is latched as N_MAX.
//  CLEAR: flt_clr=1 for exactly one cycle; cnt<=0; then go to RUN.
//  RUN: s_ready=1. On each s_valid&s_ready, next cycle: flt_en=1, flt_data=s_data
//   (registered, 1-cycle latency). Otherwise flt_en=0 and flt_data holds its value.
//   cnt increments on each accepted sample. The handshake with cnt==len-1 goes to DRAIN.
//   s_valid gaps stall the frame without limit.
//  DRAIN: s_ready=0. Wait FLT_LAT+1 cycles after the final accept, then capture:
//   m_mag<=flt_mag, m_detect<=(flt_mag>=threshold), m_valid<=1. Go to HOLD.
//  HOLD: s_ready=0. m_valid, m_mag, m_detect and m_frame stay stable until m_valid&m_ready.
//   On accept: m_valid<=0 and the frame counter increments. Then go to CLEAR if cont=1,
//   else go to IDLE. Accept on the first HOLD cycle is legal.
//  abort=1: next state IDLE and m_valid<=0. flt_en<=0, flt_clr<=0. Counters stay as they
//   are. A partial frame is discarded. abort has priority over start and m_ready.
//  Backpressure: while HOLD waits, no new samples are taken (s_ready=0).
//  flt_clr and flt_en are never high in the same cycle.
//  Reset mid-frame: state is lost immediately. A new start always clears the filter first.
// TESTING
//  1. Reset: rst_n=0 mid-RUN -> all outputs 0 in the same cycle; busy=0 after release.
//  2. Single frame: frame_len=4, cont=0, 4 back-to-back samples, m_ready=1
//     -> flt_clr pulses once, flt_en high 4 cycles, m_valid 1 cycle FLT_LAT+1 after
//     the last flt_en, m_frame=0, then IDLE.
//  3. Threshold: flt_mag=1000 at capture; threshold=1000 -> m_detect=1; threshold=1001 -> m_detect=0.
//  4. Gaps and backpressure: frame_len=3, s_valid toggling, m_ready low for 5 cycles
//     -> exactly 3 flt_en pulses; m_* stable through HOLD; s_ready=0 during HOLD.
//  5. Continuous: cont=1, frame_len=2, 3 frames -> m_frame 0,1,2; a flt_clr pulse before
//     each frame; abort after frame 3 -> IDLE, m_valid=0.
//  6. Edge cases: frame_len=0 -> N_MAX=205 samples per frame; start together with abort
//     -> stays IDLE; start outside IDLE is ignored.

Source files
------------

// File: rtl/goertzel_frame_ctrl_if.sv
// Sample-in and result-out valid/ready bundle for goertzel_frame_ctrl.
// Ports: s_valid/s_ready/s_data (samples in), m_valid/m_ready/m_mag/m_detect/m_frame (result out).
interface goertzel_frame_ctrl_if #(
  parameter int SAMPLE_W = 14,
  parameter int MAG_W    = 40
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;
  logic                m_valid;
  logic                m_ready;
  logic [MAG_W-1:0]    m_mag;
  logic                m_detect;
  logic [15:0]         m_frame;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_mag, m_detect, m_frame
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_mag, m_detect, m_frame
  );
endinterface

// File: rtl/goertzel_frame_ctrl.sv
// Frame sequencer for a goertzel filter: clear, feed frame_len samples, drain, capture, hold.
// Ports: clk, rst_n, start/cont/abort/frame_len/threshold control, bus (slave), flt_* filter side, busy.
module goertzel_frame_ctrl #(
  parameter int SAMPLE_W = 14,
  parameter int MAG_W    = 40,
  parameter int CNT_W    = 8,
  parameter int N_MAX    = 205,
  parameter int FLT_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont,
  input  logic                abort,
  input  logic [CNT_W-1:0]    frame_len,
  input  logic [MAG_W-1:0]    threshold,
  goertzel_frame_ctrl_if.slave bus,
  output logic                flt_clr,
  output logic                flt_en,
  output logic [SAMPLE_W-1:0] flt_data,
  input  logic [MAG_W-1:0]    flt_mag,
  output logic                busy
);

  localparam int DLY_W = $clog2(FLT_LAT + 2);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RUN, DRAIN, HOLD
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    len_d;
  logic                cont_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DLY_W-1:0]    dly_q;
  logic                clr_q;
  logic                en_q;
  logic [SAMPLE_W-1:0] data_q;
  logic                mv_q;
  logic [MAG_W-1:0]    mag_q;
  logic                det_q;
  logic [15:0]         frm_q;
  logic                s_ready;
  logic                acc;

  assign s_ready      = (state_q == RUN);
  assign acc          = bus.s_valid & s_ready;
  assign busy         = (state_q != IDLE);
  assign flt_clr      = clr_q;
  assign flt_en       = en_q;
  assign flt_data     = data_q;
  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = mv_q;
  assign bus.m_mag    = mag_q;
  assign bus.m_detect = det_q;
  assign bus.m_frame  = frm_q;

  // Out-of-range lengths (0 or above N_MAX) run a full-length frame.
  always_comb begin
    len_d = frame_len;
    unique case (1'b1)
      (frame_len == '0),
      (frame_len > CNT_W'(N_MAX)): len_d = CNT_W'(N_MAX);
      default: len_d = frame_len;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      dly_q   <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      mv_q    <= 1'b0;
      mag_q   <= '0;
      det_q   <= 1'b0;
      frm_q   <= '0;
    end else begin
      clr_q <= 1'b0;
      en_q  <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        mv_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              len_q   <= len_d;
              cont_q  <= cont;
              clr_q   <= 1'b1;
              state_q <= CLEAR;
            end
          end
          CLEAR: begin
            cnt_q   <= '0;
            state_q <= RUN;
          end
          RUN: begin
            if (acc) begin
              en_q   <= 1'b1;
              data_q <= bus.s_data;
              cnt_q  <= cnt_q + CNT_W'(1);
              if (cnt_q == len_q - CNT_W'(1)) begin
                dly_q   <= '0;
                state_q <= DRAIN;
              end
            end
          end
          // Last flt_en lands in the first DRAIN cycle; flt_mag is
          // valid FLT_LAT cycles later, which is the capture cycle.
          DRAIN: begin
            if (dly_q == DLY_W'(FLT_LAT)) begin
              mag_q   <= flt_mag;
              det_q   <= (flt_mag >= threshold);
              mv_q    <= 1'b1;
              state_q <= HOLD;
            end else begin
              dly_q <= dly_q + DLY_W'(1);
            end
          end
          HOLD: begin
            if (bus.m_ready) begin
              mv_q  <= 1'b0;
              frm_q <= frm_q + 16'd1;
              if (cont_q) begin
                clr_q   <= 1'b1;
                state_q <= CLEAR;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// Directed self-checking bench for goertzel_frame_ctrl.
// Drives samples/flt_mag by hand and checks handshakes, latency and results.
module tb_goertzel_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  frame_len = '0;
  logic [39:0] threshold = '0;
  logic        flt_clr;
  logic        flt_en;
  logic [13:0] flt_data;
  logic [39:0] flt_mag = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int overlap = 0;

  goertzel_frame_ctrl_if #(.SAMPLE_W(14), .MAG_W(40)) bus ();

  goertzel_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .abort(abort), .frame_len(frame_len), .threshold(threshold),
    .bus(bus), .flt_clr(flt_clr), .flt_en(flt_en),
    .flt_data(flt_data), .flt_mag(flt_mag), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (flt_en) en_cnt++;
    if (flt_clr) clr_cnt++;
    if (flt_en && flt_clr) overlap++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] len, input logic c);
    frame_len = len;
    cont = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_on_start", 64'(flt_clr), 64'd1);
  endtask

  task automatic feed(input int n, input bit gaps, input int base);
    int sent = 0;
    int guard = 0;
    bit a;
    while (sent < n && guard < 2000) begin
      bus.s_valid = gaps ? guard[0] : 1'b1;
      bus.s_data = 14'(base + sent);
      a = bus.s_valid && bus.s_ready;
      tick();
      if (a) begin
        chk("flt_en_after_acc", 64'(flt_en), 64'd1);
        chk("flt_data", 64'(flt_data), 64'(14'(base + sent)));
        sent++;
      end
      guard++;
    end
    bus.s_valid = 1'b0;
    chk("feed_done", 64'(sent), 64'(n));
  endtask

  task automatic wait_mv(output int n);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      tick();
      n++;
    end
    chk("m_valid_seen", 64'(bus.m_valid), 64'd1);
  endtask

  initial begin
    int n;
    int e0;
    int c0;
    logic [39:0] hm;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;

    // reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mvalid", 64'(bus.m_valid), 64'd0);
    chk("rst_sready", 64'(bus.s_ready), 64'd0);
    chk("rst_fltclr", 64'(flt_clr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single frame, len 4
    e0 = en_cnt; c0 = clr_cnt;
    flt_mag = 40'd1000; threshold = 40'd500;
    bus.m_ready = 1'b1;
    start_frame(8'd4, 1'b0);
    chk("busy_clear", 64'(busy), 64'd1);
    feed(4, 1'b0, 100);
    wait_mv(n);
    chk("lat_t2", 64'(n), 64'd3);
    chk("mag_t2", 64'(bus.m_mag), 64'd1000);
    chk("det_t2", 64'(bus.m_detect), 64'd1);
    chk("frm_t2", 64'(bus.m_frame), 64'd0);
    tick();
    chk("mv_drop_t2", 64'(bus.m_valid), 64'd0);
    chk("idle_t2", 64'(busy), 64'd0);
    chk("frm_inc_t2", 64'(bus.m_frame), 64'd1);
    chk("en_cnt_t2", 64'(en_cnt - e0), 64'd4);
    chk("clr_cnt_t2", 64'(clr_cnt - c0), 64'd1);

    // threshold boundary
    threshold = 40'd1000;
    start_frame(8'd1, 1'b0);
    feed(1, 1'b0, 7);
    wait_mv(n);
    chk("det_eq", 64'(bus.m_detect), 64'd1);
    tick();
    threshold = 40'd1001;
    start_frame(8'd1, 1'b0);
    feed(1, 1'b0, 8);
    wait_mv(n);
    chk("det_gt", 64'(bus.m_detect), 64'd0);
    tick();

    // gaps and backpressure
    e0 = en_cnt;
    bus.m_ready = 1'b0;
    flt_mag = 40'd7; threshold = 40'd5;
    start_frame(8'd3, 1'b0);
    feed(3, 1'b1, 200);
    wait_mv(n);
    chk("en_cnt_t4", 64'(en_cnt - e0), 64'd3);
    hm = bus.m_mag;
    chk("mag_t4", 64'(hm), 64'd7);
    flt_mag = 40'd9; threshold = 40'd100;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_mv", 64'(bus.m_valid), 64'd1);
      chk("hold_sready", 64'(bus.s_ready), 64'd0);
      chk("hold_mag", 64'(bus.m_mag), 64'd7);
      chk("hold_det", 64'(bus.m_detect), 64'd1);
      chk("hold_frm", 64'(bus.m_frame), 64'd3);
    end
    bus.s_valid = 1'b0;
    chk("en_cnt_hold", 64'(en_cnt - e0), 64'd3);
    bus.m_ready = 1'b1;
    tick();
    chk("mv_drop_t4", 64'(bus.m_valid), 64'd0);

    // reset mid-RUN
    start_frame(8'd4, 1'b0);
    feed(1, 1'b0, 300);
    rst_n = 1'b0;
    #1;
    chk("mr_flt_en", 64'(flt_en), 64'd0);
    chk("mr_flt_data", 64'(flt_data), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_sready", 64'(bus.s_ready), 64'd0);
    chk("mr_mag", 64'(bus.m_mag), 64'd0);
    chk("mr_frm", 64'(bus.m_frame), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_busy_rel", 64'(busy), 64'd0);

    // continuous mode
    c0 = clr_cnt;
    start_frame(8'd2, 1'b1);
    for (int f = 0; f < 3; f++) begin
      feed(2, 1'b0, 400 + 2 * f);
      wait_mv(n);
      chk("lat_cont", 64'(n), 64'd3);
      chk("frm_cont", 64'(bus.m_frame), 64'(f));
      tick();
      chk("clr_next", 64'(flt_clr), 64'd1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mv", 64'(bus.m_valid), 64'd0);
    chk("abort_clr", 64'(flt_clr), 64'd0);
    chk("clr_cnt_cont", 64'(clr_cnt - c0), 64'd4);

    // frame_len=0 -> 205 samples
    e0 = en_cnt;
    start_frame(8'd0, 1'b0);
    feed(205, 1'b0, 1000);
    wait_mv(n);
    chk("lat_nmax", 64'(n), 64'd3);
    chk("en_cnt_nmax", 64'(en_cnt - e0), 64'd205);
    tick();
    chk("frm_nmax", 64'(bus.m_frame), 64'd4);

    // start with abort stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_clr", 64'(flt_clr), 64'd0);

    // start outside IDLE ignored
    start_frame(8'd2, 1'b0);
    start = 1'b1; frame_len = 8'd5; cont = 1'b1;
    tick();
    start = 1'b0;
    feed(2, 1'b0, 50);
    wait_mv(n);
    chk("lat_ign", 64'(n), 64'd3);
    tick();
    chk("ign_idle", 64'(busy), 64'd0);
    chk("frm_ign", 64'(bus.m_frame), 64'd5);

    // abort in HOLD beats m_ready
    bus.m_ready = 1'b0;
    start_frame(8'd1, 1'b0);
    feed(1, 1'b0, 60);
    wait_mv(n);
    abort = 1'b1; bus.m_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("ah_mv", 64'(bus.m_valid), 64'd0);
    chk("ah_busy", 64'(busy), 64'd0);
    chk("ah_frm", 64'(bus.m_frame), 64'd5);
    chk("overlap", 64'(overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
